// File: rtl/bus_host_arb_if.sv
// rtl/bus_host_arb_if.sv - two-host / one-device req-gnt-rvalid bus bundle
interface bus_host_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  localparam int BW = DW / 8;

  logic [1:0]         h_req_i;
  logic [1:0]         h_we_i;
  logic [1:0][AW-1:0] h_addr_i;
  logic [1:0][BW-1:0] h_be_i;
  logic [1:0][DW-1:0] h_wdata_i;
  logic [1:0]         h_gnt_o;
  logic [1:0]         h_rvalid_o;
  logic [1:0]         h_err_o;
  logic [1:0][DW-1:0] h_rdata_o;

  logic               d_req_o;
  logic               d_we_o;
  logic [AW-1:0]      d_addr_o;
  logic [BW-1:0]      d_be_o;
  logic [DW-1:0]      d_wdata_o;
  logic               d_gnt_i;
  logic               d_rvalid_i;
  logic               d_err_i;
  logic [DW-1:0]      d_rdata_i;

  logic               unexp_rsp_o;

  // Environment view: drives host requests and device responses.
  modport master (
    output h_req_i, h_we_i, h_addr_i, h_be_i, h_wdata_i,
    output d_gnt_i, d_rvalid_i, d_err_i, d_rdata_i,
    input  h_gnt_o, h_rvalid_o, h_err_o, h_rdata_o,
    input  d_req_o, d_we_o, d_addr_o, d_be_o, d_wdata_o, unexp_rsp_o
  );

  // Arbiter view.
  modport slave (
    input  h_req_i, h_we_i, h_addr_i, h_be_i, h_wdata_i,
    input  d_gnt_i, d_rvalid_i, d_err_i, d_rdata_i,
    output h_gnt_o, h_rvalid_o, h_err_o, h_rdata_o,
    output d_req_o, d_we_o, d_addr_o, d_be_o, d_wdata_o, unexp_rsp_o
  );
endinterface

// File: rtl/bus_host_arb.sv
// rtl/bus_host_arb.sv - round-robin two-host arbiter onto one in-order device port
module bus_host_arb #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  bus_host_arb_if.slave bus
);
  localparam int BW   = DW / 8;
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {ARB, LOCK} state_e;

  state_e                    state_q, state_d;
  logic                      lock_q, lock_d;
  logic                      rr_q, rr_d;
  logic                      unexp_q, unexp_d;
  logic [MaxOutstanding-1:0] fifo_q, fifo_d;
  logic [PtrW-1:0]           wptr_q, wptr_d;
  logic [PtrW-1:0]           rptr_q, rptr_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  logic sel;
  logic full;
  logic empty;
  logic req;
  logic push;
  logic pop;
  logic head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // A stalled request keeps its host on the port until the device grants it.
  always_comb begin
    sel   = 1'b0;
    full  = (cnt_q == CntW'(MaxOutstanding));
    empty = (cnt_q == '0);
    if (state_q == LOCK) begin
      sel = lock_q;
    end else if (&bus.h_req_i) begin
      sel = rr_q;
    end else begin
      sel = bus.h_req_i[1];
    end
    // Full blocks issue even when a pop lands in the same cycle.
    req  = rst_ni && !full && ((state_q == LOCK) || (|bus.h_req_i));
    push = req && bus.d_gnt_i;
    pop  = bus.d_rvalid_i && !empty;
    head = fifo_q[rptr_q];
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      ARB: begin
        if (req && !bus.d_gnt_i) begin
          state_d = LOCK;
          lock_d  = sel;
        end
      end
      LOCK: begin
        if (bus.d_gnt_i) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase

    rr_d    = push ? !sel : rr_q;
    unexp_d = unexp_q || (bus.d_rvalid_i && empty);

    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      fifo_d[wptr_q] = sel;
      wptr_d         = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      lock_q  <= 1'b0;
      rr_q    <= 1'b0;
      unexp_q <= 1'b0;
      fifo_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rr_q    <= rr_d;
      unexp_q <= unexp_d;
      fifo_q  <= fifo_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.d_req_o     = req;
  assign bus.d_we_o      = req && bus.h_we_i[sel];
  assign bus.d_addr_o    = req ? bus.h_addr_i[sel]  : '0;
  assign bus.d_be_o      = req ? bus.h_be_i[sel]    : '0;
  assign bus.d_wdata_o   = req ? bus.h_wdata_i[sel] : '0;
  assign bus.unexp_rsp_o = unexp_q;

  always_comb begin
    bus.h_gnt_o    = '0;
    bus.h_rvalid_o = '0;
    bus.h_err_o    = '0;
    bus.h_rdata_o  = '0;
    for (int i = 0; i < 2; i++) begin
      bus.h_gnt_o[i]    = push && (sel == 1'(i));
      bus.h_rvalid_o[i] = pop && (head == 1'(i));
      bus.h_err_o[i]    = pop && (head == 1'(i)) && bus.d_err_i;
      bus.h_rdata_o[i]  = (pop && (head == 1'(i))) ? bus.d_rdata_i : '0;
    end
  end

endmodule

// File: tb/tb_bus_host_arb.sv
// tb/tb_bus_host_arb.sv - directed self-checking bench for bus_host_arb
module tb_bus_host_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_host_arb_if #(.AW(32), .DW(32)) bif ();

  bus_host_arb #(.AW(32), .DW(32), .MaxOutstanding(2)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bif)
  );

  task automatic idle();
    bif.h_req_i    = '0;
    bif.h_we_i     = '0;
    bif.h_addr_i   = '0;
    bif.h_be_i     = '0;
    bif.h_wdata_i  = '0;
    bif.d_gnt_i    = 1'b0;
    bif.d_rvalid_i = 1'b0;
    bif.d_err_i    = 1'b0;
    bif.d_rdata_i  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    bif.h_req_i    = 2'b11;
    bif.d_gnt_i    = 1'b1;
    bif.d_rvalid_i = 1'b1;
    #1;
    checks++; if (bif.d_req_o !== 1'b0) begin errors++; $display("FAIL rst_dreq got %b want 0", bif.d_req_o); end
    checks++; if (bif.h_gnt_o !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", bif.h_gnt_o); end
    checks++; if (bif.h_rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", bif.h_rvalid_o); end
    checks++; if (bif.unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL rst_unexp got %b want 0", bif.unexp_rsp_o); end
    next_cycle();
    idle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [1:0] eg;
    logic [31:0] ea;
    int ph;
    idle();
    bif.h_req_i     = 2'b11;
    bif.h_addr_i[0] = 32'h100;
    bif.h_addr_i[1] = 32'h200;
    bif.h_be_i[0]   = 4'hF;
    bif.h_be_i[1]   = 4'hF;
    bif.d_gnt_i     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bif.d_rvalid_i = (k > 0);
      bif.d_rdata_i  = 32'hA000 + k;
      #1;
      eg = (k % 2 == 0) ? 2'b01 : 2'b10;
      ea = (k % 2 == 0) ? 32'h100 : 32'h200;
      checks++; if (bif.h_gnt_o !== eg) begin errors++; $display("FAIL alt_gnt[%0d] got %b want %b", k, bif.h_gnt_o, eg); end
      checks++; if (bif.d_addr_o !== ea) begin errors++; $display("FAIL alt_addr[%0d] got %h want %h", k, bif.d_addr_o, ea); end
      if (k > 0) begin
        ph = (k - 1) % 2;
        checks++; if (bif.h_rvalid_o !== 2'(1 << ph)) begin errors++; $display("FAIL alt_rvalid[%0d] got %b want %b", k, bif.h_rvalid_o, 2'(1 << ph)); end
        checks++; if (bif.h_rdata_o[ph] !== 32'hA000 + k) begin errors++; $display("FAIL alt_rdata[%0d] got %h want %h", k, bif.h_rdata_o[ph], 32'hA000 + k); end
        checks++; if (bif.h_rdata_o[1-ph] !== 32'h0) begin errors++; $display("FAIL alt_rdata_other[%0d] got %h want 0", k, bif.h_rdata_o[1-ph]); end
      end
      next_cycle();
    end
    idle();
    bif.d_rvalid_i = 1'b1;
    bif.d_rdata_i  = 32'hA006;
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b10) begin errors++; $display("FAIL alt_last_rvalid got %b want 10", bif.h_rvalid_o); end
    checks++; if (bif.h_rdata_o[1] !== 32'hA006) begin errors++; $display("FAIL alt_last_rdata got %h want a006", bif.h_rdata_o[1]); end
    next_cycle();
    idle();
  endtask

  task automatic test_lock();
    logic [1:0] eg;
    // Prime rr to host 1 with one host-0 transfer, then drain it.
    idle();
    bif.h_req_i     = 2'b01;
    bif.h_addr_i[0] = 32'h300;
    bif.d_gnt_i     = 1'b1;
    next_cycle();
    idle();
    bif.d_rvalid_i = 1'b1;
    next_cycle();
    idle();
    bif.h_addr_i[0] = 32'h300;
    bif.h_addr_i[1] = 32'h400;
    for (int k = 0; k < 4; k++) begin
      bif.h_req_i = (k == 0) ? 2'b01 : 2'b11;
      bif.d_gnt_i = (k == 3);
      #1;
      eg = (k == 3) ? 2'b01 : 2'b00;
      checks++; if (bif.d_addr_o !== 32'h300) begin errors++; $display("FAIL lock_addr[%0d] got %h want 300", k, bif.d_addr_o); end
      checks++; if (bif.h_gnt_o !== eg) begin errors++; $display("FAIL lock_gnt[%0d] got %b want %b", k, bif.h_gnt_o, eg); end
      next_cycle();
    end
    bif.h_req_i = 2'b10;
    bif.d_gnt_i = 1'b1;
    #1;
    checks++; if (bif.h_gnt_o !== 2'b10) begin errors++; $display("FAIL lock_next_gnt got %b want 10", bif.h_gnt_o); end
    checks++; if (bif.d_addr_o !== 32'h400) begin errors++; $display("FAIL lock_next_addr got %h want 400", bif.d_addr_o); end
    next_cycle();
    idle();
    bif.d_rvalid_i = 1'b1;
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b01) begin errors++; $display("FAIL lock_rsp0 got %b want 01", bif.h_rvalid_o); end
    next_cycle();
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b10) begin errors++; $display("FAIL lock_rsp1 got %b want 10", bif.h_rvalid_o); end
    next_cycle();
    idle();
  endtask

  task automatic test_full();
    logic ereq;
    idle();
    bif.h_req_i     = 2'b01;
    bif.h_addr_i[0] = 32'h800;
    bif.d_gnt_i     = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bif.d_rvalid_i = (k == 4);
      #1;
      ereq = (k < 2) || (k == 5);
      checks++; if (bif.d_req_o !== ereq) begin errors++; $display("FAIL full_dreq[%0d] got %b want %b", k, bif.d_req_o, ereq); end
      checks++; if (bif.h_gnt_o !== {1'b0, ereq}) begin errors++; $display("FAIL full_gnt[%0d] got %b want %b", k, bif.h_gnt_o, {1'b0, ereq}); end
      if (k == 4) begin
        checks++; if (bif.h_rvalid_o !== 2'b01) begin errors++; $display("FAIL full_pop got %b want 01", bif.h_rvalid_o); end
      end
      next_cycle();
    end
    idle();
    bif.d_rvalid_i = 1'b1;
    next_cycle();
    next_cycle();
    idle();
  endtask

  task automatic test_same_cycle();
    idle();
    bif.h_req_i     = 2'b01;
    bif.h_addr_i[0] = 32'h900;
    bif.d_gnt_i     = 1'b1;
    next_cycle();
    idle();
    bif.h_req_i      = 2'b10;
    bif.h_we_i       = 2'b10;
    bif.h_addr_i[1]  = 32'h500;
    bif.h_be_i[1]    = 4'hC;
    bif.h_wdata_i[1] = 32'hDEAD_BEEF;
    bif.d_gnt_i      = 1'b1;
    bif.d_rvalid_i   = 1'b1;
    bif.d_err_i      = 1'b1;
    bif.d_rdata_i    = 32'h1234;
    #1;
    checks++; if (bif.h_gnt_o !== 2'b10) begin errors++; $display("FAIL sc_gnt got %b want 10", bif.h_gnt_o); end
    checks++; if ({bif.d_we_o, bif.d_be_o, bif.d_wdata_o} !== {1'b1, 4'hC, 32'hDEAD_BEEF}) begin errors++; $display("FAIL sc_wr got %b/%h/%h want 1/c/deadbeef", bif.d_we_o, bif.d_be_o, bif.d_wdata_o); end
    checks++; if (bif.h_rvalid_o !== 2'b01) begin errors++; $display("FAIL sc_rvalid got %b want 01", bif.h_rvalid_o); end
    checks++; if (bif.h_err_o !== 2'b01) begin errors++; $display("FAIL sc_err got %b want 01", bif.h_err_o); end
    checks++; if (bif.h_rdata_o[1] !== 32'h0) begin errors++; $display("FAIL sc_rdata1 got %h want 0", bif.h_rdata_o[1]); end
    next_cycle();
    // One entry left: a single further grant must fill the FIFO.
    idle();
    bif.h_req_i = 2'b01;
    bif.d_gnt_i = 1'b1;
    #1;
    checks++; if (bif.h_gnt_o !== 2'b01) begin errors++; $display("FAIL sc_fill_gnt got %b want 01", bif.h_gnt_o); end
    next_cycle();
    #1;
    checks++; if (bif.d_req_o !== 1'b0) begin errors++; $display("FAIL sc_full_dreq got %b want 0", bif.d_req_o); end
    next_cycle();
    idle();
    bif.d_rvalid_i = 1'b1;
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b10) begin errors++; $display("FAIL sc_drain1 got %b want 10", bif.h_rvalid_o); end
    next_cycle();
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b01) begin errors++; $display("FAIL sc_drain0 got %b want 01", bif.h_rvalid_o); end
    checks++; if (bif.unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL sc_unexp got %b want 0", bif.unexp_rsp_o); end
    next_cycle();
    idle();
  endtask

  task automatic test_unexpected();
    idle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    bif.d_rvalid_i = 1'b1;
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b00) begin errors++; $display("FAIL unexp_rvalid got %b want 00", bif.h_rvalid_o); end
    next_cycle();
    bif.d_rvalid_i = 1'b0;
    checks++; if (bif.unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_set got %b want 1", bif.unexp_rsp_o); end
    repeat (3) next_cycle();
    checks++; if (bif.unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL unexp_hold got %b want 1", bif.unexp_rsp_o); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bif.unexp_rsp_o !== 1'b0) begin errors++; $display("FAIL unexp_clear got %b want 0", bif.unexp_rsp_o); end
  endtask

  task automatic test_async_reset();
    next_cycle();
    rst_n = 1'b1;
    idle();
    bif.h_req_i     = 2'b01;
    bif.h_addr_i[0] = 32'h600;
    bif.h_addr_i[1] = 32'h700;
    bif.d_gnt_i     = 1'b1;
    #1;
    checks++; if (bif.h_gnt_o !== 2'b01) begin errors++; $display("FAIL ar_gnt_a got %b want 01", bif.h_gnt_o); end
    next_cycle();
    checks++; if (bif.h_gnt_o !== 2'b01) begin errors++; $display("FAIL ar_gnt_b got %b want 01", bif.h_gnt_o); end
    next_cycle();
    bif.h_req_i = 2'b11;
    #1;
    checks++; if (bif.d_req_o !== 1'b0) begin errors++; $display("FAIL ar_full got %b want 0", bif.d_req_o); end
    #1;
    rst_n = 1'b0;
    bif.d_rvalid_i = 1'b1;
    #1;
    checks++; if ({bif.d_req_o, bif.h_gnt_o, bif.h_rvalid_o} !== 5'b0) begin errors++; $display("FAIL ar_in_rst got %b want 00000", {bif.d_req_o, bif.h_gnt_o, bif.h_rvalid_o}); end
    #1;
    rst_n = 1'b1;
    bif.d_rvalid_i = 1'b0;
    #1;
    checks++; if (bif.h_gnt_o !== 2'b01) begin errors++; $display("FAIL ar_first_gnt got %b want 01", bif.h_gnt_o); end
    checks++; if (bif.d_addr_o !== 32'h600) begin errors++; $display("FAIL ar_first_addr got %h want 600", bif.d_addr_o); end
    next_cycle();
    checks++; if (bif.h_gnt_o !== 2'b10) begin errors++; $display("FAIL ar_second_gnt got %b want 10", bif.h_gnt_o); end
    next_cycle();
    idle();
    bif.d_rvalid_i = 1'b1;
    #1;
    checks++; if (bif.h_rvalid_o !== 2'b01) begin errors++; $display("FAIL ar_rsp0 got %b want 01", bif.h_rvalid_o); end
    next_cycle();
    checks++; if (bif.h_rvalid_o !== 2'b10) begin errors++; $display("FAIL ar_rsp1 got %b want 10", bif.h_rvalid_o); end
    next_cycle();
    checks++; if (bif.h_rvalid_o !== 2'b00) begin errors++; $display("FAIL ar_stale_rsp got %b want 00", bif.h_rvalid_o); end
    next_cycle();
    bif.d_rvalid_i = 1'b0;
    checks++; if (bif.unexp_rsp_o !== 1'b1) begin errors++; $display("FAIL ar_unexp got %b want 1", bif.unexp_rsp_o); end
    next_cycle();
  endtask

  initial begin
    idle();
    repeat (2) next_cycle();
    test_reset();
    test_alternate();
    test_lock();
    test_full();
    test_same_cycle();
    test_unexpected();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/bus_host_arb.md
BUS_HOST_ARB -- requirements
Module: bus_host_arb

Interface
REQ-001 SHALL have parameter AW, default 32, address width in bits.
REQ-002 SHALL have parameter DW, default 32, data width in bits; byte-enable width DW/8.
REQ-003 SHALL have parameter MaxOutstanding, default 2, range 1-4: maximum accepted-but-unanswered transfers.
REQ-004 SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports h_req_i / h_we_i  input  [2]  per-host request and write flag.
REQ-007 SHALL have ports h_addr_i [2][AW], h_be_i [2][DW/8], h_wdata_i [2][DW]  input  per-host address, byte enables, write data.
REQ-008 SHALL have ports h_gnt_o / h_rvalid_o / h_err_o  output  [2]  per-host grant, response valid, response error.
REQ-009 SHALL have port h_rdata_o  output  [2][DW]  per-host read data.
REQ-010 SHALL have ports d_req_o / d_we_o  output  1, d_addr_o  output  AW, d_be_o  output  DW/8, d_wdata_o  output  DW  device request.
REQ-011 SHALL have ports d_gnt_i / d_rvalid_i / d_err_i  input  1, d_rdata_i  input  DW  device grant and response.
REQ-012 SHALL have port unexp_rsp_o  output  1  sticky flag: response received with nothing outstanding.

Function
REQ-013 SHALL share one device port between two hosts using the req/gnt/rvalid protocol; device responses arrive in order, at least 1 cycle after their grant.
REQ-014 SHALL keep an order FIFO of MaxOutstanding entries holding the host index of every accepted transfer; push on d_req_o && d_gnt_i, pop on d_rvalid_i.
REQ-015 SHALL force d_req_o low while the FIFO is full, even when a pop occurs in the same cycle.
REQ-016 SHALL have two states, ARB and LOCK; reset state is ARB.
REQ-017 SHALL, in ARB, select the requesting host; when both request, it SHALL select the host named by the round-robin pointer rr_q (reset value 0).
REQ-018 SHALL, in ARB, go to LOCK holding the selected index when d_req_o=1 and d_gnt_i=0; it SHALL stay in ARB when granted.
REQ-019 SHALL, in LOCK, drive only the locked host onto the device port regardless of the other host, and return to ARB on d_gnt_i.
REQ-020 SHALL set rr_q to the index of the other host on every accepted transfer; rr_q SHALL otherwise hold.
REQ-021 SHALL derive d_req_o, d_we_o, d_addr_o, d_be_o and d_wdata_o combinationally from the selected host; d_* SHALL be 0 when d_req_o=0.
REQ-022 SHALL set h_gnt_o[i] = d_gnt_i && d_req_o && (selected==i), combinationally, and never to both hosts.
REQ-023 SHALL route d_rvalid_i, d_rdata_i and d_err_i to the host at the FIFO head; h_rdata_o/h_err_o SHALL be 0 for the non-addressed host.
REQ-024 SHALL, on a grant and a response in the same cycle, perform push and pop together with the count unchanged.
REQ-025 SHALL, on d_rvalid_i with an empty FIFO, drive no h_rvalid_o and set unexp_rsp_o, which SHALL stay set until reset.
REQ-026 SHALL add zero cycles of latency in either direction.

Reset
REQ-027 SHALL, while rst_ni=0, force state ARB, rr_q=0, FIFO empty, unexp_rsp_o=0, all h_gnt_o/h_rvalid_o/h_err_o=0, d_req_o=0.
REQ-028 SHALL, on reset mid-operation, discard outstanding entries; later device responses SHALL be flagged per REQ-025.

Verification
REQ-029 Both hosts request reads continuously, d_gnt_i=1, d_rvalid_i 1 cycle later -> grants alternate 0,1,0,1 and each host receives its own rdata in issue order.
REQ-030 Host 0 requests and d_gnt_i is held 0 for 3 cycles while host 1 starts requesting -> d_addr_o stays host-0 address for all 4 cycles; host 1 is granted in the cycle after host 0's grant.
REQ-031 MaxOutstanding=2, grants with no response -> third request sees d_req_o=0 until the first d_rvalid_i, then issues on the following cycle.
REQ-032 Host 1 write granted in the same cycle the response to an outstanding host-0 read arrives with d_err_i=1 -> h_rvalid_o[0]=1, h_err_o[0]=1, h_rvalid_o[1]=0, FIFO count unchanged.
REQ-033 d_rvalid_i pulsed after reset with no requests -> no h_rvalid_o; unexp_rsp_o=1 and holds until rst_ni low.
REQ-034 rst_ni asserted asynchronously mid-cycle with 2 outstanding -> outputs clear immediately; first grant after release goes to host 0 when both request.
